// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode encodings.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_COUNT   = 2'b01,
        MODE_CHASE   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Prescaler: counts 0..DIV-1, exposes the wrap condition combinationally and
// a registered one-cycle tick pulse on the cycle after the wrap.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic o_Wrap,
    output logic o_Tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    assign o_Wrap = (r_cnt == LAST);
    assign o_Tick = r_tick;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= o_Wrap;
            r_cnt  <= o_Wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step timing, registered mode copy and the
// COUNT / CHASE / BREATHE engines driving a registered LED bus.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CLK_HZ   = 25000000,
    parameter int TICK_HZ  = 1000,
    parameter int RATE_W   = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [1:0]          i_Mode,
    input  logic [RATE_W-1:0]   i_Rate,
    output logic [NUM_LEDS-1:0] o_LED,
    output logic                o_Tick,
    output logic                o_Step
);

    localparam int                   DIV        = CLK_HZ / TICK_HZ;
    localparam logic [PWM_BITS-1:0]  DUTY_MAX   = '1;
    localparam logic [NUM_LEDS-1:0]  CHASE_INIT = NUM_LEDS'(1);

    logic w_wrap;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .o_Wrap (w_wrap),
        .o_Tick (o_Tick)
    );

    mode_e               r_mode;
    logic [RATE_W-1:0]   r_step_cnt;
    logic [NUM_LEDS-1:0] r_count;
    logic [NUM_LEDS-1:0] r_chase;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir_down;
    logic [PWM_BITS-1:0] r_pwm;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_step;

    mode_e               w_mode_in;
    logic                w_mode_change;
    logic                w_step_evt;
    logic [RATE_W-1:0]   w_step_cnt_nxt;
    logic [NUM_LEDS-1:0] w_count_nxt;
    logic [NUM_LEDS-1:0] w_chase_nxt;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_dir_down_nxt;
    logic [PWM_BITS-1:0] w_pwm_nxt;
    logic [NUM_LEDS-1:0] w_led_nxt;
    logic                w_step_nxt;

    assign w_mode_in     = mode_e'(i_Mode);
    assign w_mode_change = (w_mode_in != r_mode);
    // ">=" rather than "==" so a live lowering of i_Rate fires on the next tick.
    assign w_step_evt    = w_wrap && (r_step_cnt >= i_Rate);

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_step_cnt_nxt = r_step_cnt;
        w_count_nxt    = r_count;
        w_chase_nxt    = r_chase;
        w_duty_nxt     = r_duty;
        w_dir_down_nxt = r_dir_down;
        w_pwm_nxt      = r_pwm + PWM_BITS'(1);
        w_step_nxt     = 1'b0;
        w_led_nxt      = '0;

        if (w_mode_change) begin
            // Mode reload wins over a coincident step, which is dropped.
            w_step_cnt_nxt = '0;
            w_count_nxt    = '0;
            w_chase_nxt    = CHASE_INIT;
            w_duty_nxt     = '0;
            w_dir_down_nxt = 1'b0;
        end else if (w_wrap) begin
            if (w_step_evt) begin
                w_step_cnt_nxt = '0;
                w_step_nxt     = 1'b1;
                case (r_mode)
                    MODE_COUNT: w_count_nxt = r_count + NUM_LEDS'(1);
                    MODE_CHASE: w_chase_nxt = NUM_LEDS'({r_chase, r_chase} >> (NUM_LEDS - 1));
                    MODE_BREATHE: begin
                        if (!r_dir_down) begin
                            if (r_duty == DUTY_MAX) begin
                                w_dir_down_nxt = 1'b1;
                                w_duty_nxt     = r_duty - PWM_BITS'(1);
                            end else begin
                                w_duty_nxt     = r_duty + PWM_BITS'(1);
                            end
                        end else begin
                            if (r_duty == '0) begin
                                w_dir_down_nxt = 1'b0;
                                w_duty_nxt     = r_duty + PWM_BITS'(1);
                            end else begin
                                w_duty_nxt     = r_duty - PWM_BITS'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                w_step_cnt_nxt = r_step_cnt + RATE_W'(1);
            end
        end

        // The LED register is loaded from next-state values so it shows a new
        // pattern on the same cycle o_Step is high.
        case (w_mode_in)
            MODE_COUNT:   w_led_nxt = w_count_nxt;
            MODE_CHASE:   w_led_nxt = w_chase_nxt;
            MODE_BREATHE: w_led_nxt = {NUM_LEDS{w_pwm_nxt < w_duty_nxt}};
            default:      w_led_nxt = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_mode     <= MODE_OFF;
            r_step_cnt <= '0;
            r_count    <= '0;
            r_chase    <= CHASE_INIT;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
            r_pwm      <= '0;
            r_led      <= '0;
            r_step     <= 1'b0;
        end else begin
            r_mode     <= w_mode_in;
            r_step_cnt <= w_step_cnt_nxt;
            r_count    <= w_count_nxt;
            r_chase    <= w_chase_nxt;
            r_duty     <= w_duty_nxt;
            r_dir_down <= w_dir_down_nxt;
            r_pwm      <= w_pwm_nxt;
            r_led      <= w_led_nxt;
            r_step     <= w_step_nxt;
        end
    end

    assign o_LED  = r_led;
    assign o_Step = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (DIV=10, 4 LEDs, 4-bit PWM).
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int NUM_LEDS = 4;
    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int RATE_W   = 8;
    localparam int PWM_BITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          mode;
    logic [RATE_W-1:0]   rate;
    logic [NUM_LEDS-1:0] led;
    logic                tick;
    logic                step;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // rising edges since the last reset edge (== PWM phase)
    int duty_m = 0;   // reference duty for BREATHE
    bit down_m = 1'b0;
    int highs;

    led_pattern_gen #(
        .NUM_LEDS (NUM_LEDS),
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .RATE_W   (RATE_W),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .i_Mode (mode),
        .i_Rate (rate),
        .o_LED  (led),
        .o_Tick (tick),
        .o_Step (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_step(input string tag, input int exp_n, input logic [3:0] exp_led);
        int n = 0;
        do begin
            clk_step();
            n++;
        end while (step !== 1'b1 && n < 100);
        check({tag, " spacing"}, n, exp_n);
        check({tag, " led"}, led, exp_led);
        check({tag, " tick"}, tick, 1);
    endtask

    task automatic no_step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            clk_step();
            check(tag, step, 0);
        end
    endtask

    // Reference BREATHE behaviour: steps land on tick edges while rate is 0.
    task automatic breathe_run(input int n, output int hi);
        logic [3:0] exp_led;
        bit         exp_step;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            clk_step();
            exp_step = (cyc % 10 == 0) && (rate == 0);
            if (exp_step) begin
                if (!down_m) begin
                    if (duty_m == 15) begin down_m = 1'b1; duty_m = 14; end
                    else duty_m++;
                end else begin
                    if (duty_m == 0) begin down_m = 1'b0; duty_m = 1; end
                    else duty_m--;
                end
            end
            exp_led = ((cyc % 16) < duty_m) ? 4'hF : 4'h0;
            if (led == 4'hF) hi++;
            check($sformatf("breathe led cyc=%0d duty=%0d", cyc, duty_m), led, exp_led);
            check($sformatf("breathe step cyc=%0d", cyc), step, exp_step);
            check($sformatf("breathe tick cyc=%0d", cyc), tick, (cyc % 10 == 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        mode = MODE_OFF;
        rate = 8'd2;
        clk_step();
        clk_step();
        cyc = 0;
        check("reset led", led, 0);
        check("reset tick", tick, 0);
        check("reset step", step, 0);
        rst = 1'b0;

        // OFF after release: ticks on cycles 10, 20, 30; LEDs dark.
        for (int i = 0; i < 30; i++) begin
            clk_step();
            check($sformatf("off tick cyc=%0d", cyc), tick, (cyc % 10 == 0));
            check($sformatf("off led cyc=%0d", cyc), led, 0);
        end

        // COUNT, rate 2: a step every 30 cycles, 0001..1111 then wrap to 0000.
        mode = MODE_COUNT;
        for (int k = 1; k <= 16; k++) begin
            wait_step($sformatf("count step %0d", k), 30, 4'(k));
        end

        // Switch to CHASE on the very edge where a COUNT step is due.
        no_step("count gap", 29);
        mode = MODE_CHASE;
        rate = 8'd0;
        clk_step();
        check("switch step dropped", step, 0);
        check("switch chase entry", led, 4'b0001);
        check("switch tick phase", tick, 1);

        // CHASE, rate 0: rotate on every tick, MSB wraps to bit 0.
        wait_step("chase 1", 10, 4'b0010);
        wait_step("chase 2", 10, 4'b0100);
        wait_step("chase 3", 10, 4'b1000);
        wait_step("chase wrap", 10, 4'b0001);

        // Lower the rate below the running step count: fires on the next tick.
        rate = 8'd5;
        no_step("chase rate5", 35);
        rate = 8'd1;
        wait_step("rate lowered", 5, 4'b0010);
        wait_step("rate 1", 20, 4'b0100);

        // BREATHE, rate 0: ramp to duty 4, then hold it to measure the PWM.
        mode   = MODE_BREATHE;
        rate   = 8'd0;
        duty_m = 0;
        down_m = 1'b0;
        breathe_run(40, highs);
        rate = 8'd3;
        breathe_run(16, highs);
        check("duty4 highs of 16", highs, 4);
        rate = 8'd0;
        // Up to 15, down to 0 (no wrap either way), back up to 9.
        breathe_run(344, highs);
        breathe_run(3, highs);

        // One-cycle reset mid-BREATHE at duty 9.
        rst = 1'b1;
        clk_step();
        check("midreset led", led, 0);
        check("midreset tick", tick, 0);
        check("midreset step", step, 0);
        rst    = 1'b0;
        cyc    = 0;
        duty_m = 0;
        down_m = 1'b0;
        breathe_run(20, highs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_LEDS, default 4: number of LED outputs, legal range 1..16.
REQ-002 Parameter CLK_HZ, default 25000000: input clock frequency.
REQ-003 Parameter TICK_HZ, default 1000: prescaler tick rate; DIV = CLK_HZ/TICK_HZ, which shall be at least 2.
REQ-004 Parameter RATE_W, default 8: width of i_Rate.
REQ-005 Parameter PWM_BITS, default 8: PWM counter and duty width.
REQ-006 Port i_Clk, input, 1: the single clock.
REQ-007 Port i_Rst, input, 1: synchronous, active-high reset.
REQ-008 Port i_Mode, input, 2: pattern select; 00 OFF, 01 COUNT, 10 CHASE, 11 BREATHE.
REQ-009 Port i_Rate, input, RATE_W: a step occurs every i_Rate+1 ticks.
REQ-010 Port o_LED, output, NUM_LEDS: registered LED drive.
REQ-011 Port o_Tick, output, 1: registered one-cycle pulse per prescaler wrap.
REQ-012 Port o_Step, output, 1: registered one-cycle pulse per pattern step.

Function
REQ-013 Prescaler shall count 0..DIV-1 and wrap to 0; o_Tick shall be high for exactly the cycle after the count equals DIV-1, giving period DIV cycles.
REQ-014 Step counter shall advance on each tick, counting 0..i_Rate.
- On the tick where step count == i_Rate, the count shall wrap to 0 and o_Step shall pulse on the next cycle.
- i_Rate=0 gives one step per tick.
REQ-015 i_Rate shall be sampled live; if it is lowered below the current step count, the step shall fire on the next tick and the count shall wrap to 0.
REQ-016 Mode shall be held in a registered copy.
- When i_Mode differs from the copy, the copy shall update on that clock.
- On that same clock, the step counter and all pattern state shall reload their mode-entry values.
- The prescaler shall not be disturbed.
REQ-017 OFF: o_LED shall be all zeros; pattern state shall be held at entry values.
REQ-018 COUNT: an NUM_LEDS-bit counter shall start at 0, increment by 1 per step, and wrap from all-ones to 0; o_LED shall equal the counter.
REQ-019 CHASE: a one-hot register shall start at bit 0 and rotate left by one per step.
- MSB shall wrap to bit 0.
- With NUM_LEDS=1, o_LED shall stay 1.
REQ-020 BREATHE: a free-running PWM counter of PWM_BITS shall increment every clock.
- Duty shall start at 0, direction up, and change by 1 per step.
- At 2^PWM_BITS-1, direction shall flip to down; at 0, it shall flip to up.
- Duty shall never wrap.
- Every bit of o_LED shall be 1 iff PWM counter < duty.
REQ-021 Latency: o_LED shall reflect a new pattern value on the cycle that o_Step is high, i.e. one clock after the internal step event.
REQ-022 A mode change coinciding with a step event: the mode reload shall take priority, and that step shall be discarded.

Reset
REQ-023 While i_Rst is high on a rising edge:
- prescaler, step counter and PWM counter shall reset to 0;
- mode copy shall reset to OFF;
- o_LED, o_Tick and o_Step shall reset to 0.
REQ-024 Reset asserted mid-pattern shall abandon the pattern; after release, the block shall behave as a fresh mode entry from OFF, with the first o_Tick DIV cycles after release.

Structure
REQ-025 A shared package led_pkg shall hold the mode encodings MODE_OFF, MODE_COUNT, MODE_CHASE and MODE_BREATHE.
REQ-026 Prescaler plus o_Tick generation shall be a sub-module tick_gen, parametrised by DIV.
REQ-027 Module led_pattern_gen shall contain the step counter, mode register and the three pattern engines.

Verification (CLK_HZ=100, TICK_HZ=10 so DIV=10; NUM_LEDS=4; PWM_BITS=4)
REQ-028 Reset release with i_Mode=00 -> o_Tick high on cycles 10, 20, 30 after release; o_LED=0000 throughout.
REQ-029 Mode 01, i_Rate=2 -> o_Step every 30 cycles; o_LED sequence 0001, 0010 … 1111, 0000 (wrap).
REQ-030 Mode 10, i_Rate=0 -> o_LED 0001, 0010, 0100, 1000, 0001 on successive ticks.
REQ-031 Mode 11, i_Rate=0 -> duty ramps 0→15→0; at duty 4 each LED is high 4 of every 16 cycles; no wrap past 15 or 0.
REQ-032 Switch mode 01→10 on the same cycle a step is due -> step discarded; o_LED=0001 (chase entry); prescaler phase unchanged.
REQ-033 Assert i_Rst for 1 cycle in BREATHE at duty 9 -> all outputs 0 next cycle; first o_Tick 10 cycles after release.
